// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decode/issue register in front of the ALU. Decodes one RV32I integer or
//   branch instruction per cycle, picks register or immediate operands,
//   optionally forwards the in-flight ALU result, and registers A, B, CONTROL
//   and the writeback/branch sideband for the EX cycle.
//
//   Build option: define ALU_FWD_EN to forward RESULT on a dependency instead
//   of stalling for one cycle (HAZARD then stays 0).
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready   instruction handshake (in_ready is combinational)
//   instr               raw instruction
//   rs1_data, rs2_data  register-file read data
//   result              current ALU output (forwarding source)
//   stall, flush        downstream hold / kill in-flight and incoming
//   a, b, control       registered ALU operands and operation code
//   out_valid           registered outputs describe a live instruction
//   reg_write, rd       writeback sideband
//   branch, br_inv      conditional branch, taken on ZERO=0 when br_inv
//   illegal             unsupported encoding
//   hazard              issue blocked by an operand dependency

module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] result,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      control,
  output logic            out_valid,
  output logic            reg_write,
  output logic [4:0]      rd,
  output logic            branch,
  output logic            br_inv,
  output logic            illegal,
  output logic            hazard
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] CTL_ADD = 4'b0000;
  localparam logic [3:0] CTL_SUB = 4'b0001;
  localparam logic [3:0] CTL_AND = 4'b0010;
  localparam logic [3:0] CTL_OR  = 4'b0011;
  localparam logic [3:0] CTL_XOR = 4'b0100;
  localparam logic [3:0] CTL_SLT = 4'b0101;
  localparam logic [3:0] CTL_SLL = 4'b1000;
  localparam logic [3:0] CTL_SRL = 4'b1001;
  localparam logic [3:0] CTL_BEQ = 4'b1010;
  localparam logic [3:0] CTL_BLT = 4'b1011;
  localparam logic [3:0] CTL_BGE = 4'b1100;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign funct7  = instr[31:25];

  logic [3:0] dec_ctl;
  logic       dec_regw;
  logic       dec_branch;
  logic       dec_inv;
  logic       dec_ill;
  logic       dec_imm;
  logic       dec_shift;
  logic       rs2_used;

  always_comb begin
    dec_ctl    = CTL_ADD;
    dec_regw   = 1'b0;
    dec_branch = 1'b0;
    dec_inv    = 1'b0;
    dec_ill    = 1'b0;
    dec_imm    = 1'b0;
    dec_shift  = 1'b0;
    rs2_used   = 1'b0;

    case (opcode)
      OPC_OP: begin
        rs2_used = 1'b1;
        dec_regw = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec_ctl = CTL_ADD;
          {7'h20, 3'b000}: dec_ctl = CTL_SUB;
          {7'h00, 3'b111}: dec_ctl = CTL_AND;
          {7'h00, 3'b110}: dec_ctl = CTL_OR;
          {7'h00, 3'b100}: dec_ctl = CTL_XOR;
          {7'h00, 3'b010}: dec_ctl = CTL_SLT;
          {7'h00, 3'b001}: begin dec_ctl = CTL_SLL; dec_shift = 1'b1; end
          {7'h00, 3'b101}: begin dec_ctl = CTL_SRL; dec_shift = 1'b1; end
          default:         dec_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_imm  = 1'b1;
        dec_regw = 1'b1;
        case (funct3)
          3'b000: dec_ctl = CTL_ADD;
          3'b111: dec_ctl = CTL_AND;
          3'b110: dec_ctl = CTL_OR;
          3'b100: dec_ctl = CTL_XOR;
          3'b010: dec_ctl = CTL_SLT;
          // shift-immediates carry funct7 in imm[11:5]; SRAI is not supported
          3'b001: begin
            dec_ctl   = CTL_SLL;
            dec_shift = 1'b1;
            dec_ill   = (funct7 != 7'h00);
          end
          3'b101: begin
            dec_ctl   = CTL_SRL;
            dec_shift = 1'b1;
            dec_ill   = (funct7 != 7'h00);
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        rs2_used   = 1'b1;
        dec_branch = 1'b1;
        case (funct3)
          3'b000: dec_ctl = CTL_BEQ;
          3'b001: begin dec_ctl = CTL_BEQ; dec_inv = 1'b1; end
          3'b100: dec_ctl = CTL_BLT;
          3'b101: dec_ctl = CTL_BGE;
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase

    if (dec_ill) begin
      dec_ctl    = CTL_ADD;
      dec_regw   = 1'b0;
      dec_branch = 1'b0;
      dec_inv    = 1'b0;
    end
    if (rd_idx == 5'd0) dec_regw = 1'b0;
  end

  // dependency against the instruction currently in EX
  logic ex_writes;
  logic dep_rs1;
  logic dep_rs2;

  assign ex_writes = out_valid & reg_write & (rd != 5'd0);
  assign dep_rs1   = ex_writes & (rs1_idx == rd);
  assign dep_rs2   = ex_writes & rs2_used & (rs2_idx == rd);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] rs2_val;

`ifdef ALU_FWD_EN
  assign hazard  = 1'b0;
  assign op_a    = dep_rs1 ? result : rs1_data;
  assign rs2_val = dep_rs2 ? result : rs2_data;
`else
  // the register file is written as EX retires, so one bubble is enough
  assign hazard  = in_valid & (dep_rs1 | dep_rs2);
  assign op_a    = rs1_data;
  assign rs2_val = rs2_data;
  logic unused_result;
  assign unused_result = ^result;
`endif

  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] b_pre;
  logic [XLEN-1:0] op_b;

  assign imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign b_pre   = dec_imm ? imm_ext : rs2_val;
  assign op_b    = dec_shift ? {{(XLEN-5){1'b0}}, b_pre[4:0]} : b_pre;

  assign in_ready = flush | (~stall & ~hazard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a         <= '0;
      b         <= '0;
      control   <= '0;
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      rd        <= '0;
      branch    <= 1'b0;
      br_inv    <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (stall) begin
      out_valid <= out_valid;
    end else if (in_valid && in_ready) begin
      a         <= op_a;
      b         <= op_b;
      control   <= dec_ctl;
      out_valid <= 1'b1;
      reg_write <= dec_regw;
      rd        <= rd_idx;
      branch    <= dec_branch;
      br_inv    <= dec_inv;
      illegal   <= dec_ill;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] result;
  logic        stall;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  control;
  logic        out_valid;
  logic        reg_write;
  logic [4:0]  rd;
  logic        branch;
  logic        br_inv;
  logic        illegal;
  logic        hazard;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .result(result),
    .stall(stall), .flush(flush), .a(a), .b(b), .control(control),
    .out_valid(out_valid), .reg_write(reg_write), .rd(rd), .branch(branch),
    .br_inv(br_inv), .illegal(illegal), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  ctl;
    logic        br;
    logic        inv;
    logic        rw;
    logic        ill;
    logic        chk_b;
    logic [31:0] bexp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // all vectors use rs1=x0, rs2=x0 so no dependency arises between rows
    vecs[0]  = '{32'h000003B3, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678}; // ADD
    vecs[1]  = '{32'h000063B3, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678}; // OR
    vecs[2]  = '{32'h000043B3, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678}; // XOR
    vecs[3]  = '{32'h000023B3, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678}; // SLT
    vecs[4]  = '{32'h000053B3, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000018}; // SRL
    vecs[5]  = '{32'h000073B3, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678}; // AND
    vecs[6]  = '{32'h00405393, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000004}; // SRLI 4
    vecs[7]  = '{32'hFFF06393, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF}; // ORI -1
    vecs[8]  = '{32'h00000063, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678}; // BEQ
    vecs[9]  = '{32'h00004063, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678}; // BLT
    vecs[10] = '{32'h00005063, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678}; // BGE
    vecs[11] = '{32'h400053B3, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};        // SRA unsupported
    vecs[12] = '{32'h00003393, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};        // SLTIU unsupported
    vecs[13] = '{32'h00100013, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000001}; // ADDI x0 -> no write
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    instr    = 32'h0;
    rs1_data = 32'h0;
    rs2_data = 32'h0;
    result   = 32'h0;
    stall    = 1'b0;
    flush    = 1'b0;

    // reset state
    tick();
    check_val("rst_out_valid", 32'(out_valid), 32'h0);
    check_val("rst_a", a, 32'h0);
    check_val("rst_b", b, 32'h0);
    check_val("rst_control", 32'(control), 32'h0);
    check_val("rst_reg_write", 32'(reg_write), 32'h0);
    check_val("rst_in_ready", 32'(in_ready), 32'h1);
    tick();
    reset = 1'b0;

    // basic issue: ADDI x1,x0,5
    instr = 32'h00500093; rs1_data = 32'h0; in_valid = 1'b1;
    tick();
    check_val("addi_a", a, 32'h0);
    check_val("addi_b", b, 32'h5);
    check_val("addi_control", 32'(control), 32'h0);
    check_val("addi_reg_write", 32'(reg_write), 32'h1);
    check_val("addi_rd", 32'(rd), 32'h1);
    check_val("addi_out_valid", 32'(out_valid), 32'h1);

    // dependent ADDI x2,x1,1 with stale register data
    instr = 32'h00108113; rs1_data = 32'h0; result = 32'h5;
`ifdef ALU_FWD_EN
    #1;
    check_val("fwd_hazard", 32'(hazard), 32'h0);
    tick();
    check_val("fwd_a", a, 32'h5);
    check_val("fwd_b", b, 32'h1);
    check_val("fwd_out_valid", 32'(out_valid), 32'h1);
`else
    #1;
    check_val("dep_hazard", 32'(hazard), 32'h1);
    check_val("dep_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_val("bubble_out_valid", 32'(out_valid), 32'h0);
    rs1_data = 32'h5; result = 32'hDEAD0000;
    #1;
    check_val("post_hazard", 32'(hazard), 32'h0);
    tick();
    check_val("dep_a", a, 32'h5);
    check_val("dep_b", b, 32'h1);
    check_val("dep_out_valid", 32'(out_valid), 32'h1);
`endif
    check_val("dep_rd", 32'(rd), 32'h2);

    // bubble so the next vector carries no dependency
    in_valid = 1'b0;
    tick();
    check_val("idle_out_valid", 32'(out_valid), 32'h0);

    // SUB x3,x1,x2
    in_valid = 1'b1; instr = 32'h402081B3; rs1_data = 32'h7; rs2_data = 32'h3;
    tick();
    check_val("sub_control", 32'(control), 32'h1);
    check_val("sub_a", a, 32'h7);
    check_val("sub_b", b, 32'h3);
    check_val("sub_rd", 32'(rd), 32'h3);

    // BNE x1,x2
    instr = 32'h00209463;
    tick();
    check_val("bne_control", 32'(control), 32'hA);
    check_val("bne_branch", 32'(branch), 32'h1);
    check_val("bne_br_inv", 32'(br_inv), 32'h1);
    check_val("bne_reg_write", 32'(reg_write), 32'h0);

    // SLLI x5,x1,3
    instr = 32'h00309293; rs1_data = 32'h9;
    tick();
    check_val("slli_b", b, 32'h3);
    check_val("slli_control", 32'(control), 32'h8);
    check_val("slli_a", a, 32'h9);
    check_val("slli_br_inv", 32'(br_inv), 32'h0);

    // SLL x6,x1,x2 with upper rs2 bits set
    instr = 32'h00209333; rs2_data = 32'hFFFFFF23;
    tick();
    check_val("sll_b", b, 32'h3);
    check_val("sll_control", 32'(control), 32'h8);
    check_val("sll_rd", 32'(rd), 32'h6);

    // stall for three cycles with a new instruction offered
    stall = 1'b1; instr = 32'h00500093; rs1_data = 32'h0;
    #1;
    check_val("stall_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("stall_out_valid", 32'(out_valid), 32'h1);
      check_val("stall_b", b, 32'h3);
      check_val("stall_rd", 32'(rd), 32'h6);
    end
    flush = 1'b1;
    #1;
    check_val("flush_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_val("flush_out_valid", 32'(out_valid), 32'h0);
    check_val("flush_rd_hold", 32'(rd), 32'h6);
    flush = 1'b0; stall = 1'b0;

    // decode table, back to back
    rs1_data = 32'h0; rs2_data = 32'h12345678;
    foreach (vecs[i]) begin
      instr = vecs[i].ins;
      tick();
      check_val($sformatf("vec%0d_control", i), 32'(control), 32'(vecs[i].ctl));
      check_val($sformatf("vec%0d_branch", i), 32'(branch), 32'(vecs[i].br));
      check_val($sformatf("vec%0d_br_inv", i), 32'(br_inv), 32'(vecs[i].inv));
      check_val($sformatf("vec%0d_reg_write", i), 32'(reg_write), 32'(vecs[i].rw));
      check_val($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
      check_val($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'h1);
      if (vecs[i].chk_b) check_val($sformatf("vec%0d_b", i), b, vecs[i].bexp);
    end

    // all-ones encoding
    instr = 32'hFFFFFFFF;
    tick();
    check_val("ill_illegal", 32'(illegal), 32'h1);
    check_val("ill_control", 32'(control), 32'h0);
    check_val("ill_out_valid", 32'(out_valid), 32'h1);
    check_val("ill_reg_write", 32'(reg_write), 32'h0);
    check_val("ill_branch", 32'(branch), 32'h0);

    // asynchronous reset between edges
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_val("arst_out_valid", 32'(out_valid), 32'h0);
    check_val("arst_illegal", 32'(illegal), 32'h0);
    check_val("arst_a", a, 32'h0);
    check_val("arst_b", b, 32'h0);
    check_val("arst_rd", 32'(rd), 32'h0);
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
